// File: rtl/inst_fetch_queue_if.sv
// Fetch-unit bus: inst SRAM port, branch redirect input and decode-side handshake.
// The fetch unit takes the master side; SRAM/decode environment takes the slave side.
interface inst_fetch_queue_if #(
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    logic                         inst_sram_en;
    logic [3:0]                   inst_sram_we;
    logic [31:0]                  inst_sram_addr;
    logic [31:0]                  inst_sram_wdata;
    logic [INST_W-1:0]            inst_sram_rdata;
    logic                         br_taken;
    logic [31:0]                  br_target;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_pc;
    logic [INST_W-1:0]            out_inst;
    logic [$clog2(DEPTH+1)-1:0]   queue_count;

    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        input  br_taken, br_target,
        output out_valid, out_pc, out_inst, queue_count,
        input  out_ready
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        output br_taken, br_target,
        input  out_valid, out_pc, out_inst, queue_count,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC generation, 1-cycle inst SRAM access and a
// DEPTH-entry instruction FIFO toward decode, flushed by branch redirects.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          INST_W   = 32
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_queue_if.master bus
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q;
    logic              pend_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [31:0]       pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic              out_valid, pop, push, issue;
    logic [CW:0]       budget;

    // The issue budget counts the in-flight request as occupied so a push can never hit a full FIFO.
    always_comb begin
        out_valid = ~reset & ~bus.br_taken & (cnt_q != '0);
        pop       = out_valid & bus.out_ready;
        push      = ~reset & pend_q & ~bus.br_taken;
        budget    = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q} - {{CW{1'b0}}, pop};
        issue     = ~reset & ~bus.br_taken & (budget < DEPTH_C);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        pc_d      = issue ? pc_q + 32'd4 : pc_q;
    end

    assign bus.inst_sram_en    = issue;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = 32'b0;
    assign bus.out_valid       = out_valid;
    assign bus.out_pc          = pc_mem_q[rd_ptr_q];
    assign bus.out_inst        = inst_mem_q[rd_ptr_q];
    assign bus.queue_count     = reset ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (bus.br_taken) begin
            // Redirect drops the FIFO and the response arriving this cycle.
            pc_q     <= {bus.br_target[31:2], 2'b00};
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= issue;
            cnt_q  <= cnt_d;
            if (issue) req_pc_q <= pc_q;
            if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            inst_mem_q[wr_ptr_q] <= bus.inst_sram_rdata;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed latency/stall/redirect/reset
// scenarios plus a randomized run against a queue-based fetch-order model.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] key = 32'h0;

    inst_fetch_queue_if #(.INST_W(32), .DEPTH(DEPTH)) ifc ();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .INST_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    // SRAM model: 1-cycle read latency, data is address scrambled by key.
    always @(posedge clk)
        if (ifc.inst_sram_en) ifc.inst_sram_rdata <= ifc.inst_sram_addr ^ key;

    task automatic do_reset(input int cyc);
        @(negedge clk);
        reset = 1'b1; ifc.br_taken = 1'b0; ifc.out_ready = 1'b1; ifc.br_target = 32'h0;
        for (int i = 0; i < cyc; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (ifc.inst_sram_en !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.queue_count !== '0) begin
                errors++;
                $display("FAIL reset_outputs got en=%b valid=%b cnt=%0d exp en=0 valid=0 cnt=0",
                         ifc.inst_sram_en, ifc.out_valid, ifc.queue_count);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        key = 32'h0;
        do_reset(2);
        #1;
        checks++;
        if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_first_fetch got en=%b addr=%h exp en=1 addr=%h",
                     ifc.inst_sram_en, ifc.inst_sram_addr, RESET_PC);
        end
        checks++;
        if (ifc.inst_sram_we !== 4'b0 || ifc.inst_sram_wdata !== 32'b0) begin
            errors++;
            $display("FAIL reset_we_wdata got we=%b wdata=%h exp 0", ifc.inst_sram_we, ifc.inst_sram_wdata);
        end
    endtask

    task automatic test_stream();
        key = 32'h0;
        do_reset(1);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            ifc.out_ready = 1'b1;
            #1;
            checks++;
            if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== RESET_PC + 32'(4 * c)) begin
                errors++;
                $display("FAIL stream_fetch c=%0d got en=%b addr=%h exp en=1 addr=%h",
                         c, ifc.inst_sram_en, ifc.inst_sram_addr, RESET_PC + 32'(4 * c));
            end
            checks++;
            if (c < 2) begin
                if (ifc.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early_valid c=%0d got %b exp 0", c, ifc.out_valid);
                end
            end else if (ifc.out_valid !== 1'b1 || ifc.out_pc !== RESET_PC + 32'(4 * (c - 2)) ||
                         ifc.out_inst !== RESET_PC + 32'(4 * (c - 2))) begin
                errors++;
                $display("FAIL stream_out c=%0d got v=%b pc=%h inst=%h exp v=1 pc=inst=%h",
                         c, ifc.out_valid, ifc.out_pc, ifc.out_inst, RESET_PC + 32'(4 * (c - 2)));
            end
        end
    endtask

    task automatic test_stall();
        int issued = 0;
        logic [31:0] exp_pc;
        key = 32'h5a5a_0f0f;
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            ifc.out_ready = 1'b0;
            #1;
            if (ifc.inst_sram_en === 1'b1) issued++;
        end
        checks++;
        if (issued != DEPTH) begin
            errors++;
            $display("FAIL stall_issue_count got %0d exp %0d", issued, DEPTH);
        end
        checks++;
        if (ifc.queue_count !== 3'(DEPTH) || ifc.inst_sram_en !== 1'b0 ||
            ifc.out_valid !== 1'b1 || ifc.out_pc !== RESET_PC) begin
            errors++;
            $display("FAIL stall_full got cnt=%0d en=%b v=%b pc=%h exp cnt=%0d en=0 v=1 pc=%h",
                     ifc.queue_count, ifc.inst_sram_en, ifc.out_valid, ifc.out_pc, DEPTH, RESET_PC);
        end
        exp_pc = RESET_PC;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ifc.out_ready = 1'b1;
            #1;
            if (c == 0) begin
                checks++;
                if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== RESET_PC + 32'h10) begin
                    errors++;
                    $display("FAIL stall_resume got en=%b addr=%h exp en=1 addr=%h",
                             ifc.inst_sram_en, ifc.inst_sram_addr, RESET_PC + 32'h10);
                end
            end
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_pc !== exp_pc || ifc.out_inst !== (exp_pc ^ key)) begin
                errors++;
                $display("FAIL stall_drain c=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         c, ifc.out_valid, ifc.out_pc, ifc.out_inst, exp_pc, exp_pc ^ key);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect();
        key = 32'h1234_8765;
        do_reset(1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            ifc.out_ready = 1'b0;
        end
        // Now 3 entries are queued and one response is in flight.
        @(negedge clk);
        ifc.br_taken = 1'b1; ifc.br_target = 32'h1c000403; ifc.out_ready = 1'b1;
        #1;
        checks++;
        if (ifc.queue_count !== 3'd3 || ifc.inst_sram_en !== 1'b0 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle got cnt=%0d en=%b v=%b exp cnt=3 en=0 v=0",
                     ifc.queue_count, ifc.inst_sram_en, ifc.out_valid);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ifc.br_taken = 1'b0; ifc.out_ready = 1'b1;
            #1;
            if (c == 1) begin
                checks++;
                if (ifc.queue_count !== '0 || ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1c000400) begin
                    errors++;
                    $display("FAIL redirect_next got cnt=%0d en=%b addr=%h exp cnt=0 en=1 addr=1c000400",
                             ifc.queue_count, ifc.inst_sram_en, ifc.inst_sram_addr);
                end
            end
            checks++;
            if (c < 3 && ifc.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_bubble c=%0d got v=%b exp 0", c, ifc.out_valid);
            end else if (c == 3 && (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h1c000400 ||
                                    ifc.out_inst !== (32'h1c000400 ^ key))) begin
                errors++;
                $display("FAIL redirect_target got v=%b pc=%h inst=%h exp v=1 pc=1c000400 inst=%h",
                         ifc.out_valid, ifc.out_pc, ifc.out_inst, 32'h1c000400 ^ key);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit saw_100 = 1'b0;
        key = 32'h0;
        do_reset(1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            ifc.out_ready = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ifc.br_taken = 1'b1; ifc.br_target = (c == 0) ? 32'h100 : 32'h200;
            #1;
            checks++;
            if (ifc.inst_sram_en !== 1'b0 || ifc.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold c=%0d got en=%b v=%b exp en=0 v=0", c, ifc.inst_sram_en, ifc.out_valid);
            end
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ifc.br_taken = 1'b0;
            #1;
            if (ifc.inst_sram_en === 1'b1 && ifc.inst_sram_addr === 32'h100) saw_100 = 1'b1;
            if (c == 1) begin
                checks++;
                if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL b2b_first got en=%b addr=%h exp en=1 addr=00000200",
                             ifc.inst_sram_en, ifc.inst_sram_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h200) begin
                    errors++;
                    $display("FAIL b2b_out got v=%b pc=%h exp v=1 pc=00000200", ifc.out_valid, ifc.out_pc);
                end
            end
        end
        checks++;
        if (saw_100) begin
            errors++;
            $display("FAIL b2b_no_100 got fetch of 00000100 exp none");
        end
    endtask

    task automatic test_random();
        logic [31:0] inflight[$];
        logic [31:0] exp_fetch, head, prev_pc, prev_inst;
        bit prev_stall = 1'b0;
        int pops = 0;
        key = $urandom;
        do_reset(1);
        exp_fetch = RESET_PC;
        for (int c = 0; c < 1000; c++) begin
            if (c > 0) @(negedge clk);
            ifc.out_ready = 1'($urandom_range(0, 1));
            ifc.br_taken  = ($urandom_range(0, 39) == 0);
            ifc.br_target = $urandom;
            #1;
            checks++;
            if (ifc.queue_count > 3'(DEPTH) || ifc.inst_sram_we !== 4'b0 || ifc.inst_sram_wdata !== 32'b0) begin
                errors++;
                $display("FAIL rnd_invariants c=%0d got cnt=%0d we=%b wdata=%h exp cnt<=%0d we=0 wdata=0",
                         c, ifc.queue_count, ifc.inst_sram_we, ifc.inst_sram_wdata, DEPTH);
            end
            if (prev_stall && ifc.out_valid === 1'b1) begin
                checks++;
                if (ifc.out_pc !== prev_pc || ifc.out_inst !== prev_inst) begin
                    errors++;
                    $display("FAIL rnd_stall_stable c=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                             c, ifc.out_pc, ifc.out_inst, prev_pc, prev_inst);
                end
            end
            if (ifc.br_taken) begin
                checks++;
                if (ifc.inst_sram_en !== 1'b0 || ifc.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_br_quiet c=%0d got en=%b v=%b exp 0 0", c, ifc.inst_sram_en, ifc.out_valid);
                end
                inflight.delete();
                exp_fetch = {ifc.br_target[31:2], 2'b00};
                prev_stall = 1'b0;
                continue;
            end
            if (ifc.out_valid === 1'b1 && ifc.out_ready) begin
                checks++;
                head = (inflight.size() > 0) ? inflight.pop_front() : 32'hxxxxxxxx;
                pops++;
                if (ifc.out_pc !== head || ifc.out_inst !== (head ^ key)) begin
                    errors++;
                    $display("FAIL rnd_order c=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                             c, ifc.out_pc, ifc.out_inst, head, head ^ key);
                end
            end
            if (ifc.inst_sram_en === 1'b1) begin
                checks++;
                if (ifc.inst_sram_addr !== exp_fetch) begin
                    errors++;
                    $display("FAIL rnd_fetch_addr c=%0d got %h exp %h", c, ifc.inst_sram_addr, exp_fetch);
                end
                inflight.push_back(exp_fetch);
                exp_fetch += 32'd4;
            end
            prev_stall = (ifc.out_valid === 1'b1) && !ifc.out_ready;
            prev_pc    = ifc.out_pc;
            prev_inst  = ifc.out_inst;
        end
        ifc.br_taken = 1'b0;
        checks++;
        if (pops < 250) begin
            errors++;
            $display("FAIL rnd_progress got %0d pops exp >=250", pops);
        end
    endtask

    task automatic test_reset_midflight();
        key = 32'h0;
        do_reset(1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            ifc.out_ready = 1'b0;
        end
        // Reset with the FIFO full; a redirect during reset must be ignored.
        @(negedge clk);
        reset = 1'b1; ifc.br_taken = 1'b1; ifc.br_target = 32'h300;
        #1;
        checks++;
        if (ifc.inst_sram_en !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.queue_count !== '0) begin
            errors++;
            $display("FAIL midrst_during got en=%b v=%b cnt=%0d exp 0 0 0",
                     ifc.inst_sram_en, ifc.out_valid, ifc.queue_count);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset = 1'b0; ifc.br_taken = 1'b0; ifc.out_ready = 1'b1;
            #1;
            if (c == 0) begin
                checks++;
                if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== RESET_PC || ifc.queue_count !== '0) begin
                    errors++;
                    $display("FAIL midrst_restart got en=%b addr=%h cnt=%0d exp en=1 addr=%h cnt=0",
                             ifc.inst_sram_en, ifc.inst_sram_addr, ifc.queue_count, RESET_PC);
                end
            end
            checks++;
            if (c < 2 && (ifc.out_valid !== 1'b0 || ifc.queue_count !== '0)) begin
                errors++;
                $display("FAIL midrst_empty c=%0d got v=%b cnt=%0d exp v=0 cnt=0", c, ifc.out_valid, ifc.queue_count);
            end else if (c == 2 && (ifc.out_valid !== 1'b1 || ifc.out_pc !== RESET_PC)) begin
                errors++;
                $display("FAIL midrst_first got v=%b pc=%h exp v=1 pc=%h", ifc.out_valid, ifc.out_pc, RESET_PC);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ifc.br_taken = 1'b0; ifc.br_target = 32'h0; ifc.out_ready = 1'b1;
        ifc.inst_sram_rdata = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
